// File: rtl/axi_portal_initiator.sv
// axi_portal_initiator: AXI3-style bus initiator with independent single-burst
// read and write engines. User requests come in on ENA/RDY method interfaces.
// The engines issue AR/AW/W beats and hand R/B responses back to the user
// combinationally.
module axi_portal_initiator #(
  parameter logic [11:0] ID = 12'd0
) (
  input  logic        CLK,
  input  logic        nRST,
  // read request
  input  logic        rreq_enq__ENA,
  input  logic [31:0] rreq_enq_addr,
  input  logic [3:0]  rreq_enq_len,
  output logic        rreq_enq__RDY,
  // write request
  input  logic        wreq_enq__ENA,
  input  logic [31:0] wreq_enq_addr,
  input  logic [3:0]  wreq_enq_len,
  output logic        wreq_enq__RDY,
  // write beat data
  input  logic        wdata_enq__ENA,
  input  logic [31:0] wdata_enq_v,
  output logic        wdata_enq__RDY,
  // read beats to user
  output logic        rdata_enq__ENA,
  output logic [31:0] rdata_enq_v,
  output logic        rdata_enq_last,
  input  logic        rdata_enq__RDY,
  // write completion to user
  output logic        wdone_enq__ENA,
  output logic [1:0]  wdone_enq_resp,
  input  logic        wdone_enq__RDY,
  // AR channel
  output logic        MAXIGP0_O_AR__ENA,
  output logic [31:0] MAXIGP0_O_AR_addr,
  output logic [11:0] MAXIGP0_O_AR_id,
  output logic [3:0]  MAXIGP0_O_AR_len,
  input  logic        MAXIGP0_O_AR__RDY,
  // AW channel
  output logic        MAXIGP0_O_AW__ENA,
  output logic [31:0] MAXIGP0_O_AW_addr,
  output logic [11:0] MAXIGP0_O_AW_id,
  output logic [3:0]  MAXIGP0_O_AW_len,
  input  logic        MAXIGP0_O_AW__RDY,
  // W channel
  output logic        MAXIGP0_O_W__ENA,
  output logic [31:0] MAXIGP0_O_W_data,
  output logic [11:0] MAXIGP0_O_W_id,
  output logic        MAXIGP0_O_W_last,
  input  logic        MAXIGP0_O_W__RDY,
  // R channel
  input  logic        MAXIGP0_I_R__ENA,
  input  logic [31:0] MAXIGP0_I_R_data,
  input  logic [11:0] MAXIGP0_I_R_id,
  input  logic        MAXIGP0_I_R_last,
  input  logic [1:0]  MAXIGP0_I_R_resp,
  output logic        MAXIGP0_I_R__RDY,
  // B channel
  input  logic        MAXIGP0_I_B__ENA,
  input  logic [11:0] MAXIGP0_I_B_id,
  input  logic [1:0]  MAXIGP0_I_B_resp,
  output logic        MAXIGP0_I_B__RDY,
  // sticky protocol error
  output logic        error
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [1:0]  r_state_reg;
  logic [31:0] raddr_reg;
  logic [3:0]  rlen_reg;
  logic [3:0]  rcnt_reg;

  logic [1:0]  w_state_reg;
  logic [31:0] waddr_reg;
  logic [3:0]  wlen_reg;
  logic [3:0]  wsend_reg;
  logic [4:0]  wfill_reg;
  logic [31:0] wbuf_reg;
  logic        wvalid_reg;

  logic        error_reg;

  logic rreq_fire, ar_fire, r_fire, r_end, r_err;
  logic wreq_fire, aw_fire, wd_fire, w_fire, b_fire, b_err;

  // ---------------- read side ----------------
  assign rreq_enq__RDY     = (r_state_reg == R_IDLE);
  assign MAXIGP0_O_AR__ENA = (r_state_reg == R_ADDR);
  assign MAXIGP0_O_AR_addr = raddr_reg;
  assign MAXIGP0_O_AR_len  = rlen_reg;
  // id is only presented while the address is valid so idle outputs stay at 0
  assign MAXIGP0_O_AR_id   = MAXIGP0_O_AR__ENA ? ID : 12'd0;

  // R passes straight through to the user; backpressure is combinational
  assign MAXIGP0_I_R__RDY  = (r_state_reg == R_DATA) & rdata_enq__RDY;
  assign rdata_enq__ENA    = (r_state_reg == R_DATA) & MAXIGP0_I_R__ENA;
  assign rdata_enq_v       = rdata_enq__ENA ? MAXIGP0_I_R_data : 32'd0;
  assign rdata_enq_last    = rdata_enq__ENA & MAXIGP0_I_R_last;

  assign rreq_fire = rreq_enq__ENA & rreq_enq__RDY;
  assign ar_fire   = MAXIGP0_O_AR__ENA & MAXIGP0_O_AR__RDY;
  assign r_fire    = MAXIGP0_I_R__ENA & MAXIGP0_I_R__RDY;
  // a missing last on the final counted beat still terminates the burst
  assign r_end     = r_fire & (MAXIGP0_I_R_last | (rcnt_reg == 4'd0));
  assign r_err     = r_fire & ((MAXIGP0_I_R_id != ID) | (MAXIGP0_I_R_resp != 2'd0) |
                               (MAXIGP0_I_R_last != (rcnt_reg == 4'd0)));

  // read engine: request capture, address phase, beat counting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state_reg <= R_IDLE;
      raddr_reg   <= 32'd0;
      rlen_reg    <= 4'd0;
      rcnt_reg    <= 4'd0;
    end else begin
      case (r_state_reg)
        R_IDLE: if (rreq_fire) begin
          raddr_reg   <= rreq_enq_addr;
          rlen_reg    <= rreq_enq_len;
          rcnt_reg    <= rreq_enq_len;
          r_state_reg <= R_ADDR;
        end
        R_ADDR: if (ar_fire) r_state_reg <= R_DATA;
        R_DATA: if (r_fire) begin
          if (rcnt_reg != 4'd0) rcnt_reg <= rcnt_reg - 4'd1;
          if (r_end) r_state_reg <= R_IDLE;
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // ---------------- write side ----------------
  assign wreq_enq__RDY     = (w_state_reg == W_IDLE);
  assign MAXIGP0_O_AW__ENA = (w_state_reg == W_ADDR);
  assign MAXIGP0_O_AW_addr = waddr_reg;
  assign MAXIGP0_O_AW_len  = wlen_reg;
  assign MAXIGP0_O_AW_id   = MAXIGP0_O_AW__ENA ? ID : 12'd0;

  // one-entry buffer: refill only once the previous beat has left
  assign wdata_enq__RDY    = (w_state_reg == W_DATA) & ~wvalid_reg & (wfill_reg != 5'd0);
  assign MAXIGP0_O_W__ENA  = wvalid_reg;
  assign MAXIGP0_O_W_data  = wbuf_reg;
  assign MAXIGP0_O_W_id    = wvalid_reg ? ID : 12'd0;
  assign MAXIGP0_O_W_last  = wvalid_reg & (wsend_reg == 4'd0);

  assign MAXIGP0_I_B__RDY  = (w_state_reg == W_RESP) & wdone_enq__RDY;
  assign wdone_enq__ENA    = (w_state_reg == W_RESP) & MAXIGP0_I_B__ENA;
  assign wdone_enq_resp    = wdone_enq__ENA ? MAXIGP0_I_B_resp : 2'd0;

  assign wreq_fire = wreq_enq__ENA & wreq_enq__RDY;
  assign aw_fire   = MAXIGP0_O_AW__ENA & MAXIGP0_O_AW__RDY;
  assign wd_fire   = wdata_enq__ENA & wdata_enq__RDY;
  assign w_fire    = MAXIGP0_O_W__ENA & MAXIGP0_O_W__RDY;
  assign b_fire    = MAXIGP0_I_B__ENA & MAXIGP0_I_B__RDY;
  assign b_err     = b_fire & ((MAXIGP0_I_B_id != ID) | (MAXIGP0_I_B_resp != 2'd0));

  // write engine: request capture, address phase, beat buffer, response wait
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      w_state_reg <= W_IDLE;
      waddr_reg   <= 32'd0;
      wlen_reg    <= 4'd0;
      wsend_reg   <= 4'd0;
      wfill_reg   <= 5'd0;
      wbuf_reg    <= 32'd0;
      wvalid_reg  <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: if (wreq_fire) begin
          waddr_reg   <= wreq_enq_addr;
          wlen_reg    <= wreq_enq_len;
          wsend_reg   <= wreq_enq_len;
          wfill_reg   <= {1'b0, wreq_enq_len} + 5'd1;
          w_state_reg <= W_ADDR;
        end
        W_ADDR: if (aw_fire) w_state_reg <= W_DATA;
        W_DATA: begin
          if (wd_fire) begin
            wbuf_reg   <= wdata_enq_v;
            wvalid_reg <= 1'b1;
            wfill_reg  <= wfill_reg - 5'd1;
          end
          if (w_fire) begin
            wvalid_reg <= 1'b0;
            if (wsend_reg == 4'd0) w_state_reg <= W_RESP;
            else wsend_reg <= wsend_reg - 4'd1;
          end
        end
        W_RESP: if (b_fire) w_state_reg <= W_IDLE;
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // sticky error, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) error_reg <= 1'b0;
    else if (r_err | b_err) error_reg <= 1'b1;
  end

  assign error = error_reg;

endmodule

// File: tb/tb_axi_portal_initiator.sv
// Directed testbench for axi_portal_initiator.
module tb_axi_portal_initiator;

  localparam logic [11:0] TID = 12'h5A3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        rreq_enq__ENA, wreq_enq__ENA, wdata_enq__ENA;
  logic [31:0] rreq_enq_addr, wreq_enq_addr, wdata_enq_v;
  logic [3:0]  rreq_enq_len, wreq_enq_len;
  logic        rreq_enq__RDY, wreq_enq__RDY, wdata_enq__RDY;
  logic        rdata_enq__ENA, rdata_enq_last, rdata_enq__RDY;
  logic [31:0] rdata_enq_v;
  logic        wdone_enq__ENA, wdone_enq__RDY;
  logic [1:0]  wdone_enq_resp;
  logic        AR_ENA, AR_RDY, AW_ENA, AW_RDY, W_ENA, W_RDY, W_LAST;
  logic [31:0] AR_ADDR, AW_ADDR, W_DATA;
  logic [11:0] AR_ID, AW_ID, W_ID;
  logic [3:0]  AR_LEN, AW_LEN;
  logic        R_ENA, R_LAST, R_RDY, B_ENA, B_RDY;
  logic [31:0] R_DATA;
  logic [11:0] R_ID, B_ID;
  logic [1:0]  R_RESP, B_RESP;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  axi_portal_initiator #(.ID(TID)) dut (
    .CLK(CLK), .nRST(nRST),
    .rreq_enq__ENA(rreq_enq__ENA), .rreq_enq_addr(rreq_enq_addr),
    .rreq_enq_len(rreq_enq_len), .rreq_enq__RDY(rreq_enq__RDY),
    .wreq_enq__ENA(wreq_enq__ENA), .wreq_enq_addr(wreq_enq_addr),
    .wreq_enq_len(wreq_enq_len), .wreq_enq__RDY(wreq_enq__RDY),
    .wdata_enq__ENA(wdata_enq__ENA), .wdata_enq_v(wdata_enq_v),
    .wdata_enq__RDY(wdata_enq__RDY),
    .rdata_enq__ENA(rdata_enq__ENA), .rdata_enq_v(rdata_enq_v),
    .rdata_enq_last(rdata_enq_last), .rdata_enq__RDY(rdata_enq__RDY),
    .wdone_enq__ENA(wdone_enq__ENA), .wdone_enq_resp(wdone_enq_resp),
    .wdone_enq__RDY(wdone_enq__RDY),
    .MAXIGP0_O_AR__ENA(AR_ENA), .MAXIGP0_O_AR_addr(AR_ADDR),
    .MAXIGP0_O_AR_id(AR_ID), .MAXIGP0_O_AR_len(AR_LEN), .MAXIGP0_O_AR__RDY(AR_RDY),
    .MAXIGP0_O_AW__ENA(AW_ENA), .MAXIGP0_O_AW_addr(AW_ADDR),
    .MAXIGP0_O_AW_id(AW_ID), .MAXIGP0_O_AW_len(AW_LEN), .MAXIGP0_O_AW__RDY(AW_RDY),
    .MAXIGP0_O_W__ENA(W_ENA), .MAXIGP0_O_W_data(W_DATA),
    .MAXIGP0_O_W_id(W_ID), .MAXIGP0_O_W_last(W_LAST), .MAXIGP0_O_W__RDY(W_RDY),
    .MAXIGP0_I_R__ENA(R_ENA), .MAXIGP0_I_R_data(R_DATA), .MAXIGP0_I_R_id(R_ID),
    .MAXIGP0_I_R_last(R_LAST), .MAXIGP0_I_R_resp(R_RESP), .MAXIGP0_I_R__RDY(R_RDY),
    .MAXIGP0_I_B__ENA(B_ENA), .MAXIGP0_I_B_id(B_ID), .MAXIGP0_I_B_resp(B_RESP),
    .MAXIGP0_I_B__RDY(B_RDY),
    .error(error)
  );

  always #5 CLK = ~CLK;

  // single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-18s obs=0x%08h", tag, obs);
    end else begin
      $display("FAIL %-18s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    rreq_enq__ENA = 0; rreq_enq_addr = 0; rreq_enq_len = 0;
    wreq_enq__ENA = 0; wreq_enq_addr = 0; wreq_enq_len = 0;
    wdata_enq__ENA = 0; wdata_enq_v = 0;
    rdata_enq__RDY = 1; wdone_enq__RDY = 1;
    AR_RDY = 0; AW_RDY = 0; W_RDY = 1;
    R_ENA = 0; R_DATA = 0; R_ID = TID; R_LAST = 0; R_RESP = 0;
    B_ENA = 0; B_ID = TID; B_RESP = 0;
  endtask

  task automatic do_reset();
    nRST = 0;
    idle_inputs();
    #2;
    check("rst_rreq_rdy", {31'd0, rreq_enq__RDY}, 1);
    check("rst_wreq_rdy", {31'd0, wreq_enq__RDY}, 1);
    check("rst_enas", {26'd0, AR_ENA, AW_ENA, W_ENA, rdata_enq__ENA, wdone_enq__ENA, wdata_enq__RDY}, 0);
    check("rst_rb_rdy_err", {29'd0, R_RDY, B_RDY, error}, 0);
    check("rst_fields", AR_ADDR | AW_ADDR | W_DATA | {20'd0, AR_ID} | {20'd0, W_ID} | {31'd0, W_LAST}, 0);
    tick(); tick();
    nRST = 1;
    tick();
  endtask

  int k, hold, cyc;

  initial begin
    do_reset();

    // ---- read single beat ----
    rreq_enq__ENA = 1; rreq_enq_addr = 32'h10; rreq_enq_len = 0;
    tick();                                   // t
    rreq_enq__ENA = 0;
    #1;
    check("rd1_ar_ena", {31'd0, AR_ENA}, 1);
    check("rd1_ar_addr", AR_ADDR, 32'h10);
    check("rd1_ar_len", {28'd0, AR_LEN}, 0);
    check("rd1_ar_id", {20'd0, AR_ID}, {20'd0, TID});
    check("rd1_rreq_busy", {31'd0, rreq_enq__RDY}, 0);
    tick();                                   // t+2, still waiting
    check("rd1_ar_hold", {AR_LEN, 27'd0, AR_ENA} ^ AR_ADDR, 32'h11);
    tick();                                   // t+3
    AR_RDY = 1;
    tick();
    AR_RDY = 0;
    R_ENA = 1; R_DATA = 32'hCAFEF00D; R_LAST = 1; R_ID = TID;
    #1;
    check("rd1_ar_done", {31'd0, AR_ENA}, 0);
    check("rd1_r_rdy", {31'd0, R_RDY}, 1);
    check("rd1_rdata_ena", {31'd0, rdata_enq__ENA}, 1);
    check("rd1_rdata_v", rdata_enq_v, 32'hCAFEF00D);
    check("rd1_rdata_last", {31'd0, rdata_enq_last}, 1);
    tick();
    R_ENA = 0; R_LAST = 0;
    #1;
    check("rd1_rreq_back", {31'd0, rreq_enq__RDY}, 1);
    check("rd1_r_rdy_off", {31'd0, R_RDY}, 0);
    check("rd1_error", {31'd0, error}, 0);

    // ---- write 4-beat burst ----
    wreq_enq__ENA = 1; wreq_enq_addr = 32'h4; wreq_enq_len = 3;
    tick();
    wreq_enq__ENA = 0;
    #1;
    check("wr4_aw_ena", {31'd0, AW_ENA}, 1);
    check("wr4_aw_addr", AW_ADDR, 32'h4);
    check("wr4_aw_len", {28'd0, AW_LEN}, 3);
    check("wr4_wd_rdy_addr", {31'd0, wdata_enq__RDY}, 0);
    AW_RDY = 1;
    tick();
    AW_RDY = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("wr4_wd_rdy", {31'd0, wdata_enq__RDY}, 1);
      wdata_enq__ENA = 1; wdata_enq_v = i + 1;
      tick();
      wdata_enq__ENA = 0;
      #1;
      check("wr4_w_ena", {31'd0, W_ENA}, 1);
      check("wr4_w_data", W_DATA, i + 1);
      check("wr4_w_last", {31'd0, W_LAST}, (i == 3) ? 1 : 0);
      check("wr4_wd_rdy_full", {31'd0, wdata_enq__RDY}, 0);
      tick();
    end
    #1;
    check("wr4_w_off", {31'd0, W_ENA}, 0);
    check("wr4_b_rdy", {31'd0, B_RDY}, 1);
    B_ENA = 1; B_RESP = 0; B_ID = TID;
    #1;
    check("wr4_wdone_ena", {31'd0, wdone_enq__ENA}, 1);
    check("wr4_wdone_resp", {30'd0, wdone_enq_resp}, 0);
    tick();
    B_ENA = 0;
    #1;
    check("wr4_wreq_back", {31'd0, wreq_enq__RDY}, 1);
    check("wr4_error", {31'd0, error}, 0);

    // ---- 16-beat read with user backpressure ----
    rreq_enq__ENA = 1; rreq_enq_addr = 32'h200; rreq_enq_len = 15;
    tick();
    rreq_enq__ENA = 0;
    AR_RDY = 1;
    #1;
    check("bp_ar_len", {28'd0, AR_LEN}, 15);
    tick();
    AR_RDY = 0;
    k = 0; hold = 0; cyc = 0;
    while (k < 16 && cyc < 100) begin
      R_ENA = 1; R_DATA = 32'h1000 + k; R_LAST = (k == 15); R_ID = TID; R_RESP = 0;
      rdata_enq__RDY = !(k == 6 && hold < 5);
      #1;
      if (!rdata_enq__RDY) begin
        check("bp_hold_r_rdy", {31'd0, R_RDY}, 0);
        hold++;
      end else begin
        check("bp_r_rdy", {31'd0, R_RDY}, 1);
        check("bp_rdata_v", rdata_enq_v, 32'h1000 + k);
        check("bp_rdata_last", {31'd0, rdata_enq_last}, (k == 15) ? 1 : 0);
        k++;
      end
      tick();
      cyc++;
    end
    R_ENA = 0; R_LAST = 0; rdata_enq__RDY = 1;
    #1;
    check("bp_beats", k, 16);
    check("bp_rreq_back", {31'd0, rreq_enq__RDY}, 1);
    check("bp_error", {31'd0, error}, 0);

    // ---- read error: last=1 while rcnt=2 ----
    rreq_enq__ENA = 1; rreq_enq_addr = 32'h40; rreq_enq_len = 3;
    tick();
    rreq_enq__ENA = 0; AR_RDY = 1;
    tick();
    AR_RDY = 0;
    R_ENA = 1; R_DATA = 32'hA; R_LAST = 0;    // rcnt 3 -> 2
    tick();
    #1;
    check("rerr_no_err_yet", {31'd0, error}, 0);
    R_DATA = 32'hB; R_LAST = 1;               // premature last
    tick();
    R_ENA = 0; R_LAST = 0;
    #1;
    check("rerr_error", {31'd0, error}, 1);
    check("rerr_idle", {31'd0, rreq_enq__RDY}, 1);

    // ---- write error: single beat, B resp=2 ----
    do_reset();
    wreq_enq__ENA = 1; wreq_enq_addr = 32'h80; wreq_enq_len = 0;
    tick();
    wreq_enq__ENA = 0; AW_RDY = 1;
    tick();
    AW_RDY = 0;
    wdata_enq__ENA = 1; wdata_enq_v = 32'h55;
    tick();
    wdata_enq__ENA = 0;
    #1;
    check("werr_w_last", {31'd0, W_LAST}, 1);
    tick();
    B_ENA = 1; B_RESP = 2;
    #1;
    check("werr_wdone_resp", {30'd0, wdone_enq_resp}, 2);
    tick();
    B_ENA = 0; B_RESP = 0;
    #1;
    check("werr_error", {31'd0, error}, 1);

    // ---- concurrent read + write, reset mid-write ----
    do_reset();
    rreq_enq__ENA = 1; rreq_enq_addr = 32'h300; rreq_enq_len = 1;
    wreq_enq__ENA = 1; wreq_enq_addr = 32'h400; wreq_enq_len = 3;
    tick();
    rreq_enq__ENA = 0; wreq_enq__ENA = 0;
    #1;
    check("cc_ar_aw", {30'd0, AR_ENA, AW_ENA}, 3);
    AR_RDY = 1; AW_RDY = 1;
    tick();
    AR_RDY = 0; AW_RDY = 0;
    R_ENA = 1; R_DATA = 32'h77; R_LAST = 0;
    wdata_enq__ENA = 1; wdata_enq_v = 32'h1;
    tick();
    wdata_enq__ENA = 0;
    R_DATA = 32'h78; R_LAST = 1;
    #1;
    check("cc_rdata_last", {31'd0, rdata_enq_last}, 1);
    check("cc_w_data1", W_DATA, 32'h1);
    tick();
    R_ENA = 0; R_LAST = 0;
    #1;
    check("cc_read_done", {31'd0, rreq_enq__RDY}, 1);
    check("cc_write_busy", {31'd0, wreq_enq__RDY}, 0);
    wdata_enq__ENA = 1; wdata_enq_v = 32'h2;
    tick();
    wdata_enq__ENA = 0;
    #1;
    check("cc_w_data2", W_DATA, 32'h2);
    tick();
    wdata_enq__ENA = 1; wdata_enq_v = 32'h3;
    tick();
    wdata_enq__ENA = 0;
    #1;
    check("cc_w3_pending", {31'd0, W_ENA}, 1);
    nRST = 0;
    #1;
    check("cc_rst_enas", {27'd0, AR_ENA, AW_ENA, W_ENA, rdata_enq__ENA, wdone_enq__ENA}, 0);
    check("cc_rst_wd_rdy", {31'd0, wdata_enq__RDY}, 0);
    tick();
    nRST = 1;
    tick();
    check("cc_rel_rdys", {30'd0, rreq_enq__RDY, wreq_enq__RDY}, 3);
    check("cc_rel_error", {31'd0, error}, 0);
    check("cc_rel_w_ena", {31'd0, W_ENA}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_portal_initiator.md
# axi_portal_initiator

AXI3-style bus initiator that drives the MAXIGP0 slave-side port set of the portal responder. Single-burst read and write request queues come in on method-style ENA/RDY interfaces. The block issues AR/AW/W beats, collects R/B responses and returns them to the user. It serves as the test-side master for the portal responder and as the CPU-bus model in simulation tops.

## Interface
- ID, default 12'd0: AXI id driven on AR/AW/W; expected on R/B.
- CLK in 1: clock, rising edge.
- nRST in 1: reset, asynchronous, active-low.
- rreq$enq__ENA / rreq$enq__RDY in/out 1: read request handshake. rreq$enq$addr in 32; rreq$enq$len in 4 (beats-1).
- wreq$enq__ENA / wreq$enq__RDY in/out 1: write request handshake. wreq$enq$addr in 32; wreq$enq$len in 4 (beats-1).
- wdata$enq__ENA / wdata$enq__RDY in/out 1; wdata$enq$v in 32: write beat data.
- rdata$enq__ENA out 1; rdata$enq$v out 32; rdata$enq$last out 1; rdata$enq__RDY in 1: read beats to the user.
- wdone$enq__ENA out 1; wdone$enq$resp out 2; wdone$enq__RDY in 1: write completion.
- MAXIGP0_O$AR__ENA out 1; $AR$addr out 32; $AR$id out 12; $AR$len out 4; MAXIGP0_O$AR__RDY in 1.
- MAXIGP0_O$AW__ENA out 1; $AW$addr out 32; $AW$id out 12; $AW$len out 4; MAXIGP0_O$AW__RDY in 1.
- MAXIGP0_O$W__ENA out 1; $W$data out 32; $W$id out 12; $W$last out 1; MAXIGP0_O$W__RDY in 1.
- MAXIGP0_I$R__ENA in 1; $R$data in 32; $R$id in 12; $R$last in 1; $R$resp in 2; MAXIGP0_I$R__RDY out 1.
- MAXIGP0_I$B__ENA in 1; $B$id in 12; $B$resp in 2; MAXIGP0_I$B__RDY out 1.
- error out 1: sticky protocol-error flag.

## Operation
- Transfer rule: a transfer happens on a cycle where ENA & RDY are both high. RDY outputs never depend on same-cycle ENA or argument inputs.
- The read and write engines are independent. Each has at most one burst outstanding.

Read FSM (R_IDLE, R_ADDR, R_DATA):
- R_IDLE: rreq$enq__RDY=1. On transfer, register addr and len, load rcnt=len, go to R_ADDR.
- R_ADDR: AR__ENA=1 with the registered addr/len and id=ID. Hold all AR fields stable until AR__RDY, then go to R_DATA.
- R_DATA: pass-through. MAXIGP0_I$R__RDY = rdata$enq__RDY; rdata$enq__ENA = R__ENA; v/last forwarded.
  - Each accepted beat decrements rcnt.
  - Go to R_IDLE on the accepted beat with R$last=1.
- Read errors (set error) on an accepted R beat when any of:
  - R$id != ID;
  - R$resp != 0;
  - R$last != (rcnt==0);
  - R$last=0 with rcnt==0; this beat is also forced to end the burst.

Write FSM (W_IDLE, W_ADDR, W_DATA, W_RESP):
- W_IDLE: wreq$enq__RDY=1. On transfer, register addr/len, set wsend=len, wfill=len+1 (5 bits), go to W_ADDR.
- W_ADDR: AW__ENA=1, fields held until AW__RDY, then go to W_DATA.
- W_DATA, user side: 1-entry buffer wbuf/wvalid. wdata$enq__RDY = (W_DATA) & !wvalid & (wfill!=0). Acceptance loads wbuf, sets wvalid, decrements wfill.
- W_DATA, bus side: W__ENA = wvalid; W$data = wbuf; W$last = (wsend==0). On W transfer, clear wvalid and decrement wsend. The last-beat transfer goes to W_RESP.
- W_RESP: B__RDY = wdone$enq__RDY; wdone$enq__ENA = B__ENA; resp forwarded. On transfer go to W_IDLE.
  - B$id != ID or B$resp != 0 sets error.
- R/B beats arriving outside R_DATA/W_RESP are not accepted (R__RDY/B__RDY=0 there).
- error is cleared only by reset.

## Timing
- Reset (asynchronous, immediate): both FSMs idle. rreq$enq__RDY=1, wreq$enq__RDY=1. All other outputs 0, including all ENA, R__RDY, B__RDY, wdata$enq__RDY, error, AR/AW/W fields.
  - Reset mid-burst abandons the burst and discards wbuf without completing it.
- rreq accepted at cycle t: AR__ENA high at t+1. First R beat is acceptable the cycle after AR completes.
- wreq accepted at t: AW__ENA at t+1.
- wdata accepted at t: W__ENA at t+1.
  - The buffer refills no earlier than the cycle after W drains it, so peak write throughput is 1 beat per 2 cycles.
- R→rdata and B→wdone are combinational, zero latency, and register-free. Backpressure propagates the same cycle.
- len=0 (single beat): W$last=1 on the only beat; the read completes on its first beat.
- len=15 (16 beats): 4-bit counters count down from 15 without wrap; wfill is 5 bits to hold 16.
- A read and a write may be in flight simultaneously. Requests arriving while the engine is busy are stalled via RDY=0.

## Test plan
- Read single beat: rreq addr=0x10, len=0; AR__RDY at t+3; R data=0xCAFEF00D, last=1, id=ID. Required: AR$addr=0x10, AR$len=0; rdata v=0xCAFEF00D, last=1; rreq$enq__RDY back to 1 the next cycle; error=0.
- Write 4-beat burst: wreq addr=0x4, len=3; wdata 1,2,3,4; W__RDY always 1. Required: AW$len=3; W$data 1..4 with W$last only on the 4th beat; B resp=0 yields wdone resp=0.
- Backpressure: in a 16-beat read (len=15), hold rdata$enq__RDY=0 for 5 cycles mid-burst. Required: R__RDY=0 during the hold, no beat lost, rdata$enq$last only on the 16th beat.
- Protocol errors: an R beat with last=1 when rcnt=2 sets error=1 and the read FSM returns to idle. In a separate run, B$resp=2 sets error and wdone$enq$resp=2.
- Concurrency and reset: start a read and a write in the same cycle; both complete independently. Assert nRST low mid-write (after 2 of 4 beats). Required: all ENA outputs 0 immediately, both req RDY=1 after release, error=0.
